// File: rtl/cute_key_sequencer.sv
// Time-varying key source for Cute-Lock encrypted FSMs: a bank of NUM_PHASES keys loaded over a
// config port, then frozen and driven onto keyinput in lockstep with the locked FSM's phase counter.
module cute_key_sequencer #(
    parameter int unsigned KEY_W      = 9,
    parameter int unsigned PHASE_LEN  = 9,
    parameter int unsigned NUM_PHASES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_idx,
    input  logic [KEY_W-1:0] cfg_key,
    input  logic             cfg_commit,
    output logic             cfg_err,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic [1:0]       phase,
    output logic [5:0]       cnt
);

    localparam logic [5:0] CntMax = 6'(PHASE_LEN * NUM_PHASES - 1);

    typedef enum logic [0:0] {StLoad, StRun} state_t;

    state_t                state;
    logic [KEY_W-1:0]      key_bank [NUM_PHASES];
    logic [NUM_PHASES-1:0] written;
    logic [NUM_PHASES-1:0] written_upd;
    logic                  idx_ok;
    logic                  do_write;
    logic                  bank_full;
    logic                  reject;

    assign idx_ok    = 32'(cfg_idx) < NUM_PHASES;
    assign do_write  = cfg_valid && idx_ok && (state == StLoad);
    assign cfg_ready = do_write;

    // A same-cycle write counts towards the commit check.
    always_comb begin
        written_upd = written;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (do_write && (cfg_idx == 2'(i))) written_upd[i] = 1'b1;
        end
    end

    assign bank_full = &written_upd;

    always_comb begin
        reject = 1'b0;
        if (state == StLoad) begin
            reject = (cfg_valid && !idx_ok) || (cfg_commit && !bank_full);
        end else begin
            reject = cfg_valid || cfg_commit;
        end
    end

    always_comb begin
        phase = '0;
        for (int i = 1; i < NUM_PHASES; i++) begin
            if (cnt >= 6'(i * PHASE_LEN)) phase = 2'(i);
        end
    end

    // Keys come straight off cnt/state so they are settled before the locked FSM samples.
    assign key_valid = (state == StRun);
    assign key_out   = (state == StRun) ? key_bank[phase] : '0;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state   <= StLoad;
            cnt     <= '0;
            written <= '0;
            cfg_err <= 1'b0;
            for (int i = 0; i < NUM_PHASES; i++) key_bank[i] <= '0;
        end else begin
            cnt     <= (cnt >= CntMax) ? 6'd0 : cnt + 6'd1;
            cfg_err <= reject;
            written <= written_upd;
            if (do_write) key_bank[cfg_idx] <= cfg_key;
            if ((state == StLoad) && cfg_commit && bank_full) state <= StRun;
        end
    end

endmodule

// File: tb/tb_cute_key_sequencer.sv
// Self-checking bench for cute_key_sequencer: directed config vectors plus counter, wrap and
// mid-run reset sequences.
module tb_cute_key_sequencer;

    logic       clk = 1'b1;
    logic       rst = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [1:0] cfg_idx = 2'd0;
    logic [8:0] cfg_key = 9'd0;
    logic       cfg_commit = 1'b0;
    logic       cfg_err;
    logic [8:0] key_out;
    logic       key_valid;
    logic [1:0] phase;
    logic [5:0] cnt;

    int tests  = 0;
    int failed = 0;
    int exp_cnt = 0;
    int exp_bank [3] = '{0, 0, 0};

    typedef struct {
        logic       v;
        logic [1:0] idx;
        logic [8:0] key;
        logic       c;
        logic       rdy;
        logic       err;
        logic       kv;
    } vec_t;

    vec_t vecs [9];

    cute_key_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_idx   (cfg_idx),
        .cfg_key   (cfg_key),
        .cfg_commit(cfg_commit),
        .cfg_err   (cfg_err),
        .key_out   (key_out),
        .key_valid (key_valid),
        .phase     (phase),
        .cnt       (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one negedge and move the reference counter with it.
    task automatic step();
        @(negedge clk);
        #1;
        exp_cnt = (exp_cnt == 26) ? 0 : exp_cnt + 1;
    endtask

    task automatic chk_keys(input string name, input logic kv);
        int ph;
        ph = exp_cnt / 9;
        chk({name, " cnt"}, int'(cnt), exp_cnt);
        chk({name, " phase"}, int'(phase), ph);
        chk({name, " key_valid"}, int'(key_valid), int'(kv));
        chk({name, " key_out"}, int'(key_out), kv ? exp_bank[ph] : 0);
    endtask

    initial begin
        vecs[0] = '{v: 1, idx: 3, key: 9'd5,   c: 0, rdy: 0, err: 1, kv: 0};
        vecs[1] = '{v: 1, idx: 0, key: 9'd382, c: 0, rdy: 1, err: 0, kv: 0};
        vecs[2] = '{v: 1, idx: 1, key: 9'd461, c: 0, rdy: 1, err: 0, kv: 0};
        vecs[3] = '{v: 0, idx: 0, key: 9'd0,   c: 1, rdy: 0, err: 1, kv: 0};
        vecs[4] = '{v: 0, idx: 0, key: 9'd0,   c: 0, rdy: 0, err: 0, kv: 0};
        vecs[5] = '{v: 1, idx: 2, key: 9'd214, c: 1, rdy: 1, err: 0, kv: 1};
        vecs[6] = '{v: 1, idx: 0, key: 9'd0,   c: 0, rdy: 0, err: 1, kv: 1};
        vecs[7] = '{v: 0, idx: 0, key: 9'd0,   c: 1, rdy: 0, err: 1, kv: 1};
        vecs[8] = '{v: 0, idx: 0, key: 9'd0,   c: 0, rdy: 0, err: 0, kv: 1};

        // Reset values, then 60 idle cycles.
        #12;
        rst = 1'b0;
        #1;
        chk("reset cfg_ready", int'(cfg_ready), 0);
        chk("reset cfg_err", int'(cfg_err), 0);
        chk_keys("reset", 1'b0);
        for (int i = 0; i < 60; i++) begin
            step();
            chk_keys("idle", 1'b0);
            chk("idle cfg_err", int'(cfg_err), 0);
        end

        // Config vectors.
        for (int i = 0; i < 9; i++) begin
            cfg_valid  = vecs[i].v;
            cfg_idx    = vecs[i].idx;
            cfg_key    = vecs[i].key;
            cfg_commit = vecs[i].c;
            #1;
            chk($sformatf("vec%0d cfg_ready", i), int'(cfg_ready), int'(vecs[i].rdy));
            if (vecs[i].rdy) exp_bank[vecs[i].idx] = int'(vecs[i].key);
            step();
            cfg_valid  = 1'b0;
            cfg_commit = 1'b0;
            chk($sformatf("vec%0d cfg_err", i), int'(cfg_err), int'(vecs[i].err));
            chk_keys($sformatf("vec%0d", i), vecs[i].kv);
        end

        // Key sequence over more than two full periods, including wraps.
        for (int i = 0; i < 60; i++) begin
            step();
            chk_keys("run", 1'b1);
        end

        // Bounded wait for cnt=13, then asynchronous reset mid-window.
        for (int i = 0; i < 30 && exp_cnt != 13; i++) step();
        chk("reach cnt13", int'(cnt), 13);
        rst = 1'b1;
        #1;
        exp_cnt = 0;
        exp_bank = '{0, 0, 0};
        chk_keys("midreset", 1'b0);
        #1;
        rst = 1'b0;
        step();
        chk_keys("post reset", 1'b0);

        // Bank was cleared: bare commit must be rejected.
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
        chk("reload commit err", int'(cfg_err), 1);
        chk_keys("reload commit", 1'b0);

        // Reload distinct keys and commit with the last write.
        for (int s = 0; s < 3; s++) begin
            cfg_valid  = 1'b1;
            cfg_idx    = 2'(s);
            cfg_key    = 9'(17 + 100 * s);
            cfg_commit = (s == 2);
            exp_bank[s] = 17 + 100 * s;
            step();
        end
        cfg_valid  = 1'b0;
        cfg_commit = 1'b0;
        chk("reload cfg_err", int'(cfg_err), 0);
        chk_keys("reload", 1'b1);
        for (int i = 0; i < 30; i++) begin
            step();
            chk_keys("reload run", 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
